// File: rtl/serial_addsub.sv
// Digit-serial two's-complement adder/subtractor: DIGIT bits per cycle through a
// full-adder chain, with a registered carry/borrow linking consecutive digits.
module serial_addsub #(
    parameter int WIDTH = 8,
    parameter int DIGIT = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] D,
    output logic             Bout,
    output logic             V,
    output logic             Z,
    output logic             dbg_state_o
);
    localparam int N  = WIDTH / DIGIT;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    // Handshake: start is sampled on a rising edge only while busy=0; the operation
    // then owns the datapath until done pulses high for exactly one cycle.
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             sub_q, sub_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] dout_q, dout_d;
    logic             bout_q, bout_d;
    logic             v_q, v_d;
    logic             z_q, z_d;
    logic             done_q, done_d;

    logic [DIGIT-1:0] sum;
    logic [DIGIT:0]   chain_c;
    logic             cout;
    logic             cin_msb;
    logic             last;
    logic [WIDTH-1:0] res_next;

    // Ripple through DIGIT full adders; chain_c[0] is the carry left by the previous digit.
    always_comb begin
        chain_c    = '0;
        sum        = '0;
        chain_c[0] = carry_q;
        for (int i = 0; i < DIGIT; i++) begin
            sum[i]       = a_q[i] ^ b_q[i] ^ chain_c[i];
            chain_c[i+1] = (a_q[i] & b_q[i]) | (chain_c[i] & (a_q[i] ^ b_q[i]));
        end
    end

    assign cout    = chain_c[DIGIT];
    assign cin_msb = chain_c[DIGIT-1];
    assign last    = (cnt_q == CW'(N - 1));

    // Partial result only needs the digits already produced; the new digit enters at the MSB end.
    generate
        if (N == 1) begin : g_single
            assign res_next = sum;
        end else begin : g_multi
            logic [WIDTH-DIGIT-1:0] part_q;
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    part_q <= '0;
                end else if (state_q == RUN) begin
                    part_q <= res_next[WIDTH-1:DIGIT];
                end
            end
            assign res_next = {sum, part_q};
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        bout_d  = bout_q;
        v_d     = v_q;
        z_d     = z_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = A;
                    b_d     = sub ? ~B : B;
                    sub_d   = sub;
                    carry_d = sub;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = cout;
                cnt_d   = cnt_q + 1'b1;
                if (last) begin
                    dout_d  = res_next;
                    bout_d  = cout ^ sub_q;
                    v_d     = cin_msb ^ cout;
                    z_d     = (res_next == '0);
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            dout_q  <= '0;
            bout_q  <= 1'b0;
            v_q     <= 1'b0;
            z_q     <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
            bout_q  <= bout_d;
            v_q     <= v_d;
            z_q     <= z_d;
            done_q  <= done_d;
        end
    end

    assign busy        = (state_q == RUN);
    assign done        = done_q;
    assign D           = dout_q;
    assign Bout        = bout_q;
    assign V           = v_q;
    assign Z           = z_q;
    assign dbg_state_o = state_q;
endmodule

// File: tb/tb_serial_addsub.sv
// Bench for serial_addsub: directed handshake/reset/flag cases on WIDTH=8 DIGIT=2,
// then random operations on several WIDTH/DIGIT configurations against a reference model.
module tb_serial_addsub;
    localparam int NCFG = 5;
    localparam int EW   = 19;  // {Z, V, Bout, D[15:0]}

    function automatic int cfg_w(int g);
        return (g == 4) ? 16 : 8;
    endfunction

    function automatic int cfg_dg(int g);
        if (g == 0) return 2;
        else if (g == 1) return 1;
        else if (g == 2) return 4;
        else if (g == 3) return 8;
        else return 4;
    endfunction

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        sw_start [NCFG];
    logic        sw_sub   [NCFG];
    logic [15:0] sw_a     [NCFG];
    logic [15:0] sw_b     [NCFG];
    logic        sw_busy  [NCFG];
    logic        sw_done  [NCFG];
    logic [15:0] sw_d     [NCFG];
    logic        sw_bout  [NCFG];
    logic        sw_v     [NCFG];
    logic        sw_z     [NCFG];
    logic        sw_st    [NCFG];

    for (genvar g = 0; g < NCFG; g++) begin : g_cfg
        localparam int W  = cfg_w(g);
        localparam int DG = cfg_dg(g);
        logic [W-1:0] d_w;
        serial_addsub #(.WIDTH(W), .DIGIT(DG)) u_dut (
            .clk        (clk),
            .rst        (rst),
            .start      (sw_start[g]),
            .sub        (sw_sub[g]),
            .A          (sw_a[g][W-1:0]),
            .B          (sw_b[g][W-1:0]),
            .busy       (sw_busy[g]),
            .done       (sw_done[g]),
            .D          (d_w),
            .Bout       (sw_bout[g]),
            .V          (sw_v[g]),
            .Z          (sw_z[g]),
            .dbg_state_o(sw_st[g])
        );
        assign sw_d[g] = 16'(d_w);
    end

    int n_cmp = 0;
    int n_err = 0;
    logic [EW-1:0] exp_q[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Independent reference: wide arithmetic, then flags from operand/result signs.
    function automatic logic [EW-1:0] model(input int w, input logic s,
                                            input logic [15:0] a, input logic [15:0] b);
        logic [16:0] mask, r, am, bm;
        logic [15:0] d;
        logic        bo, v, z, sa, sb, sd;
        mask = (17'd1 << w) - 17'd1;
        am   = {1'b0, a} & mask;
        bm   = {1'b0, b} & mask;
        if (s) begin
            r  = am - bm;
            bo = (am < bm);
        end else begin
            r  = am + bm;
            bo = r[w];
        end
        d  = 16'(r & mask);
        sa = am[w-1];
        sb = bm[w-1];
        sd = d[w-1];
        v  = s ? ((sa != sb) && (sd != sa)) : ((sa == sb) && (sd != sa));
        z  = (d == 16'h0);
        return {z, v, bo, d};
    endfunction

    task automatic push_exp(input logic z, input logic v, input logic bo, input logic [15:0] d);
        exp_q.push_back({z, v, bo, d});
    endtask

    // Drive one start pulse; operands are scrambled afterwards to show they are not re-read.
    task automatic start_op(input int c, input logic s, input logic [15:0] a, input logic [15:0] b);
        sw_sub[c]   = s;
        sw_a[c]     = a;
        sw_b[c]     = b;
        sw_start[c] = 1'b1;
        tick();
        sw_start[c] = 1'b0;
        sw_sub[c]   = 1'($urandom_range(0, 1));
        sw_a[c]     = 16'($urandom);
        sw_b[c]     = 16'($urandom);
    endtask

    task automatic finish_op(input int c, input string tag, input int exp_lat);
        int cyc;
        int bcyc;
        logic [EW-1:0] e;
        cyc  = 0;
        bcyc = sw_busy[c] ? 1 : 0;
        while (cyc < 64) begin
            tick();
            cyc++;
            if (sw_done[c]) break;
            if (sw_busy[c]) bcyc++;
        end
        check({tag, "_done"}, 32'(sw_done[c]), 32'd1);
        check({tag, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({tag, "_busy_cycles"}, 32'(bcyc), 32'(exp_lat));
        check({tag, "_busy_at_done"}, 32'(sw_busy[c]), 32'd0);
        check({tag, "_sb_nonempty"}, 32'(exp_q.size() != 0), 32'd1);
        e = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
        check({tag, "_D"}, 32'(sw_d[c]), 32'(e[15:0]));
        check({tag, "_Bout"}, 32'(sw_bout[c]), 32'(e[16]));
        check({tag, "_V"}, 32'(sw_v[c]), 32'(e[17]));
        check({tag, "_Z"}, 32'(sw_z[c]), 32'(e[18]));
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_busy"}, 32'(sw_busy[0]), 32'd0);
        check({tag, "_done"}, 32'(sw_done[0]), 32'd0);
        check({tag, "_D"}, 32'(sw_d[0]), 32'd0);
        check({tag, "_Bout"}, 32'(sw_bout[0]), 32'd0);
        check({tag, "_V"}, 32'(sw_v[0]), 32'd0);
        check({tag, "_Z"}, 32'(sw_z[0]), 32'd0);
        check({tag, "_state"}, 32'(sw_st[0]), 32'd0);
    endtask

    initial begin
        int ndone;
        logic s;
        logic [15:0] a, b;

        rst = 1'b1;
        for (int c = 0; c < NCFG; c++) begin
            sw_start[c] = 1'b0;
            sw_sub[c]   = 1'b0;
            sw_a[c]     = 16'h0;
            sw_b[c]     = 16'h0;
        end
        tick();
        tick();
        tick();
        check_zero("reset");
        rst = 1'b0;
        tick();
        check_zero("post_reset");

        // Basic subtract, then done-pulse width and result hold.
        push_exp(1'b0, 1'b0, 1'b0, 16'h23);
        start_op(0, 1'b1, 16'h35, 16'h12);
        check("t1_state_run", 32'(sw_st[0]), 32'd1);
        finish_op(0, "t1", 4);
        tick();
        check("t1_done_width", 32'(sw_done[0]), 32'd0);
        check("t1_state_idle", 32'(sw_st[0]), 32'd0);
        tick();
        check("t1_hold_D", 32'(sw_d[0]), 32'h23);

        push_exp(1'b0, 1'b0, 1'b1, 16'hDD);
        start_op(0, 1'b1, 16'h12, 16'h35);
        finish_op(0, "t2", 4);
        push_exp(1'b0, 1'b1, 1'b0, 16'h7F);
        start_op(0, 1'b1, 16'h80, 16'h01);
        finish_op(0, "t3", 4);
        push_exp(1'b1, 1'b0, 1'b1, 16'h00);
        start_op(0, 1'b0, 16'hFF, 16'h01);
        finish_op(0, "t4", 4);
        push_exp(1'b0, 1'b1, 1'b0, 16'h80);
        start_op(0, 1'b0, 16'h7F, 16'h01);
        finish_op(0, "t5", 4);
        tick();

        // Start pulsed two cycles into an operation must be ignored.
        push_exp(1'b0, 1'b0, 1'b0, 16'h23);
        start_op(0, 1'b1, 16'h35, 16'h12);
        tick();
        sw_sub[0]   = 1'b0;
        sw_a[0]     = 16'hFF;
        sw_b[0]     = 16'h00;
        sw_start[0] = 1'b1;
        tick();
        sw_start[0] = 1'b0;
        finish_op(0, "ignore", 2);
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sw_done[0]) ndone++;
        end
        check("ignore_extra_done", 32'(ndone), 32'd0);
        check("ignore_hold_D", 32'(sw_d[0]), 32'h23);

        // Back-to-back: second start driven during the done cycle.
        push_exp(1'b0, 1'b0, 1'b0, 16'h30);
        start_op(0, 1'b0, 16'h10, 16'h20);
        finish_op(0, "b2b_a", 4);
        push_exp(1'b0, 1'b0, 1'b1, 16'hFE);
        start_op(0, 1'b1, 16'h05, 16'h07);
        finish_op(0, "b2b_b", 4);

        // Asynchronous reset mid-operation clears everything, no done afterwards.
        start_op(0, 1'b1, 16'h35, 16'h12);
        tick();
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        tick();
        tick();
        rst = 1'b0;
        ndone = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (sw_done[0]) ndone++;
        end
        check("rst_no_done", 32'(ndone), 32'd0);
        check("rst_idle_busy", 32'(sw_busy[0]), 32'd0);
        push_exp(1'b1, 1'b0, 1'b0, 16'h00);
        start_op(0, 1'b1, 16'h05, 16'h05);
        finish_op(0, "restart", 4);
        tick();

        // Random sweep over every configuration, mostly back-to-back.
        for (int c = 0; c < NCFG; c++) begin
            for (int i = 0; i < 1000; i++) begin
                s = 1'($urandom_range(0, 1));
                a = 16'($urandom);
                b = 16'($urandom);
                exp_q.push_back(model(cfg_w(c), s, a, b));
                start_op(c, s, a, b);
                finish_op(c, $sformatf("rand_cfg%0d", c), cfg_w(c) / cfg_dg(c));
                if ($urandom_range(0, 3) == 0) tick();
            end
        end

        check("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
